// File: rtl/nes_memory.sv
`default_nettype none
// ============================================================================
// Module   : nes_memory
// Purpose  : Byte-wide synchronous memory for the NES core. It decodes the CPU
//            map into mirrored 2 KB RAM, 8 KB work RAM, 32 KB PRG and a hole.
// Revision : 1.0 - initial release
// ============================================================================
module nes_memory #(
    parameter bit         WRAM_EN        = 1'b1,
    parameter bit         PRG_WRITABLE   = 1'b1,
    parameter logic [7:0] UNMAPPED_VALUE = 8'h00
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [15:0] addr,
    input  logic        write,
    input  logic [7:0]  in,
    output logic [7:0]  out
);

    localparam logic [2:0] c_RAM_TOP  = 3'b000;
    localparam logic [2:0] c_WRAM_TOP = 3'b011;

    logic [7:0] r_ram  [0:2047];
    logic [7:0] r_wram [0:8191];
    logic [7:0] r_prg  [0:32767];
    logic [7:0] r_out;

    logic       w_sel_ram;
    logic       w_sel_wram;
    logic       w_sel_prg;
    logic       w_writable;
    logic       w_wr_en;
    logic [7:0] w_rd_data;

    // Only the top address bits take part in the decode; indices are plain
    // slices, so the 2 KB RAM mirrors itself every $0800.
    assign w_sel_ram  = (addr[15:13] == c_RAM_TOP);
    assign w_sel_wram = WRAM_EN && (addr[15:13] == c_WRAM_TOP);
    assign w_sel_prg  = addr[15];
    assign w_writable = w_sel_ram || w_sel_wram || (w_sel_prg && PRG_WRITABLE);
    assign w_wr_en    = write && reset_n && w_writable;

    always_comb begin
        w_rd_data = UNMAPPED_VALUE;
        if (w_sel_ram) begin
            w_rd_data = r_ram[addr[10:0]];
        end else if (w_sel_wram) begin
            w_rd_data = r_wram[addr[12:0]];
        end else if (w_sel_prg) begin
            w_rd_data = r_prg[addr[14:0]];
        end
    end

    // Arrays carry no reset so they map onto block RAM and survive reset.
    always_ff @(posedge clk) begin
        if (w_wr_en && w_sel_ram) begin
            r_ram[addr[10:0]] <= in;
        end
        if (w_wr_en && w_sel_wram) begin
            r_wram[addr[12:0]] <= in;
        end
        if (w_wr_en && w_sel_prg) begin
            r_prg[addr[14:0]] <= in;
        end
    end

    // Write-first: a landing write echoes its data; an ignored write reads.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_out <= 8'h00;
        end else if (write && w_writable) begin
            r_out <= in;
        end else begin
            r_out <= w_rd_data;
        end
    end

    assign out = r_out;

endmodule
`default_nettype wire

// File: tb/tb_nes_memory.sv
`default_nettype none
// ============================================================================
// Module   : tb_nes_memory
// Purpose  : Directed scoreboard bench for nes_memory (default build plus a
//            build with work RAM disabled and PRG read-only).
// Revision : 1.0 - initial release
// ============================================================================
module tb_nes_memory;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [15:0] addr;
    logic        write;
    logic [7:0]  din;
    logic [7:0]  out_a;
    logic [7:0]  out_b;

    int n_asserts = 0;
    int n_fails   = 0;

    logic [7:0] q_exp_a[$];
    int         q_mode_b[$];
    logic [7:0] q_exp_b[$];
    string      q_tag[$];

    always #5 clk = ~clk;

    nes_memory u_dut_a (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .write   (write),
        .in      (din),
        .out     (out_a)
    );

    nes_memory #(
        .WRAM_EN        (1'b0),
        .PRG_WRITABLE   (1'b0),
        .UNMAPPED_VALUE (8'h00)
    ) u_dut_b (
        .clk     (clk),
        .reset_n (reset_n),
        .addr    (addr),
        .write   (write),
        .in      (din),
        .out     (out_b)
    );

    // mode_b: 0 = no check on the restricted build, 1 = equal, 2 = not equal
    task automatic step(input logic [15:0] a, input logic w, input logic [7:0] d,
                        input logic rn, input logic [7:0] exp_a,
                        input int mode_b, input logic [7:0] exp_b, input string tag);
        logic [7:0] e_a;
        logic [7:0] e_b;
        int         m_b;
        string      t;
        @(negedge clk);
        addr    = a;
        write   = w;
        din     = d;
        reset_n = rn;
        q_exp_a.push_back(exp_a);
        q_mode_b.push_back(mode_b);
        q_exp_b.push_back(exp_b);
        q_tag.push_back(tag);
        @(posedge clk);
        #1;
        e_a = q_exp_a.pop_front();
        m_b = q_mode_b.pop_front();
        e_b = q_exp_b.pop_front();
        t   = q_tag.pop_front();
        n_asserts++;
        assert (out_a === e_a) else begin
            n_fails++;
            $error("FAIL %s: out=%h expected=%h", t, out_a, e_a);
        end
        if (m_b == 1) begin
            n_asserts++;
            assert (out_b === e_b) else begin
                n_fails++;
                $error("FAIL %s_b: out=%h expected=%h", t, out_b, e_b);
            end
        end else if (m_b == 2) begin
            n_asserts++;
            assert (out_b !== e_b) else begin
                n_fails++;
                $error("FAIL %s_b: out=%h expected not %h", t, out_b, e_b);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset_n = 1'b0;
        addr    = 16'h0000;
        write   = 1'b0;
        din     = 8'h00;

        step(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1, 8'h00, "por_reset0");
        step(16'h0000, 1'b0, 8'h00, 1'b0, 8'h00, 1, 8'h00, "por_reset1");

        // Reset drops the concurrent write and clears out
        step(16'h0000, 1'b1, 8'h5A, 1'b1, 8'h5A, 1, 8'h5A, "init_0000");
        step(16'h0200, 1'b1, 8'hA5, 1'b1, 8'hA5, 1, 8'hA5, "pre_reset_a5");
        step(16'h0000, 1'b1, 8'h11, 1'b0, 8'h00, 1, 8'h00, "reset_edge1");
        step(16'h0000, 1'b1, 8'h11, 1'b0, 8'h00, 1, 8'h00, "reset_edge2");
        step(16'h0000, 1'b0, 8'h00, 1'b1, 8'h5A, 1, 8'h5A, "post_reset_rd");

        // Internal RAM mirrors
        step(16'h0012, 1'b1, 8'h3C, 1'b1, 8'h3C, 1, 8'h3C, "mirror_wr");
        step(16'h0812, 1'b0, 8'h00, 1'b1, 8'h3C, 1, 8'h3C, "mirror_0812");
        step(16'h1012, 1'b0, 8'h00, 1'b1, 8'h3C, 1, 8'h3C, "mirror_1012");
        step(16'h1812, 1'b0, 8'h00, 1'b1, 8'h3C, 1, 8'h3C, "mirror_1812");

        // PRG load; the read-only build must not take the data
        step(16'h8000, 1'b1, 8'hA9, 1'b1, 8'hA9, 2, 8'hA9, "prg_wr_8000");
        step(16'hFFFC, 1'b1, 8'h00, 1'b1, 8'h00, 0, 8'h00, "prg_wr_fffc");
        step(16'hFFFD, 1'b1, 8'h80, 1'b1, 8'h80, 2, 8'h80, "prg_wr_fffd");
        step(16'h8000, 1'b0, 8'h00, 1'b1, 8'hA9, 2, 8'hA9, "prg_rd_8000");
        step(16'hFFFC, 1'b0, 8'h00, 1'b1, 8'h00, 0, 8'h00, "prg_rd_fffc");
        step(16'hFFFD, 1'b0, 8'h00, 1'b1, 8'h80, 2, 8'h80, "prg_rd_fffd");

        // Unmapped hole
        step(16'h2000, 1'b1, 8'h55, 1'b1, 8'h00, 1, 8'h00, "unmap_wr_2000");
        step(16'h2000, 1'b0, 8'h00, 1'b1, 8'h00, 1, 8'h00, "unmap_rd_2000");
        step(16'h4016, 1'b0, 8'h00, 1'b1, 8'h00, 1, 8'h00, "unmap_rd_4016");
        step(16'h5FFF, 1'b1, 8'hEE, 1'b1, 8'h00, 1, 8'h00, "unmap_wr_5fff");

        // Work RAM (unmapped in the restricted build)
        step(16'h6000, 1'b1, 8'h77, 1'b1, 8'h77, 1, 8'h00, "wram_wr_6000");
        step(16'h7FFF, 1'b1, 8'h88, 1'b1, 8'h88, 1, 8'h00, "wram_wr_7fff");
        step(16'h6000, 1'b0, 8'h00, 1'b1, 8'h77, 1, 8'h00, "wram_rd_6000");
        step(16'h7FFF, 1'b0, 8'h00, 1'b1, 8'h88, 1, 8'h00, "wram_rd_7fff");
        step(16'h0000, 1'b0, 8'h00, 1'b1, 8'h5A, 1, 8'h5A, "ram_unaffected");

        // Latency, write-first and back-to-back
        step(16'h0100, 1'b1, 8'hC3, 1'b1, 8'hC3, 1, 8'hC3, "wf_0100");
        step(16'h0100, 1'b0, 8'h00, 1'b1, 8'hC3, 1, 8'hC3, "b2b_0100");
        step(16'h0101, 1'b1, 8'h3D, 1'b1, 8'h3D, 1, 8'h3D, "wf_0101");
        for (int i = 0; i < 4; i++) begin
            if (i % 2 == 0) begin
                step(16'h0100, 1'b0, 8'h00, 1'b1, 8'hC3, 1, 8'hC3, "alt_0100");
            end else begin
                step(16'h0101, 1'b0, 8'h00, 1'b1, 8'h3D, 1, 8'h3D, "alt_0101");
            end
        end
        step(16'h0901, 1'b1, 8'h4B, 1'b1, 8'h4B, 1, 8'h4B, "alias_wr_0901");
        step(16'h0101, 1'b0, 8'h00, 1'b1, 8'h4B, 1, 8'h4B, "alias_rd_0101");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
